// File: rtl/ace_request_engine.sv
// Turns single-cycle cache-controller requests into ACE master transactions:
// ReadShared line fills, WriteBack of a victim line, and dataless MakeUnique.
module ace_request_engine #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      read_req,
  input  logic                      write_req,
  input  logic                      invalid_req,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [BEATS*DATA_W-1:0]   wb_line,
  output logic                      ace_ready,
  output logic                      resp_err,
  output logic                      busy,
  output logic [BEATS*DATA_W-1:0]   fill_line,
  output logic [ADDR_W-1:0]         araddr,
  output logic [7:0]                arlen,
  output logic [3:0]                arsnoop,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [DATA_W-1:0]         rdata,
  input  logic [3:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic                      rack,
  output logic [ADDR_W-1:0]         awaddr,
  output logic [7:0]                awlen,
  output logic [2:0]                awsnoop,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [DATA_W-1:0]         wdata,
  output logic [DATA_W/8-1:0]       wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic                      wack
);

  localparam int unsigned LINE_W = BEATS * DATA_W;
  localparam int unsigned OFF_W  = $clog2(BEATS * DATA_W / 8);
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LastBeat  = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [2:0] {
    StIdle, StArSend, StRRecv, StAwSend, StWSend, StBWait, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   fill_q, fill_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                err_q, err_d;
  logic                is_wr_q, is_wr_d;
  logic                is_inv_q, is_inv_d;
  logic                last_beat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      line_q   <= '0;
      fill_q   <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      is_wr_q  <= 1'b0;
      is_inv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      line_q   <= line_d;
      fill_q   <= fill_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      is_wr_q  <= is_wr_d;
      is_inv_q <= is_inv_d;
    end
  end

  // A MakeUnique carries a single beat, so its first beat is also its last.
  assign last_beat = is_inv_q || (beat_q == LastBeat);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    line_d   = line_q;
    fill_d   = fill_q;
    beat_d   = beat_q;
    err_d    = err_q;
    is_wr_d  = is_wr_q;
    is_inv_d = is_inv_q;
    unique case (state_q)
      StIdle: begin
        if (write_req) begin
          state_d  = StAwSend;
          is_wr_d  = 1'b1;
          is_inv_d = 1'b0;
          line_d   = wb_line;
          addr_d   = req_addr & AlignMask;
          err_d    = 1'b0;
          beat_d   = '0;
        end else if (invalid_req || read_req) begin
          state_d  = StArSend;
          is_wr_d  = 1'b0;
          is_inv_d = invalid_req;
          addr_d   = req_addr & AlignMask;
          err_d    = 1'b0;
          beat_d   = '0;
        end
      end
      StArSend: if (arready) state_d = StRRecv;
      StRRecv: begin
        if (rvalid) begin
          if (!is_inv_q) fill_d[beat_q*DATA_W +: DATA_W] = rdata;
          // Termination follows the beat count; rlast is only cross-checked.
          if ((rresp[1:0] != 2'b00) || (rlast != last_beat)) err_d = 1'b1;
          if (last_beat) begin
            state_d = StDone;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StAwSend: if (awready) state_d = StWSend;
      StWSend: begin
        if (wready) begin
          if (beat_q == LastBeat) begin
            state_d = StBWait;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StBWait: begin
        if (bvalid) begin
          if (bresp != 2'b00) err_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign ace_ready = (state_q == StDone);
  assign resp_err  = ace_ready && err_q;
  assign rack      = ace_ready && !is_wr_q;
  assign wack      = ace_ready && is_wr_q;
  assign fill_line = fill_q;

  assign araddr  = addr_q;
  assign arlen   = is_inv_q ? 8'd0 : 8'(BEATS - 1);
  assign arsnoop = is_inv_q ? 4'b1100 : 4'b0001;
  assign arvalid = (state_q == StArSend);
  assign rready  = (state_q == StRRecv);

  assign awaddr  = addr_q;
  assign awlen   = 8'(BEATS - 1);
  assign awsnoop = 3'b011;
  assign awvalid = (state_q == StAwSend);
  assign wvalid  = (state_q == StWSend);
  assign wdata   = line_q[beat_q*DATA_W +: DATA_W];
  assign wstrb   = '1;
  assign wlast   = wvalid && (beat_q == LastBeat);
  assign bready  = (state_q == StBWait);

endmodule

// File: tb/tb_ace_request_engine.sv
// Directed bench for ace_request_engine: a small reactive ACE slave model drives the
// interconnect side and logs what the engine issues.
module tb_ace_request_engine;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned LINE_W = BEATS * DATA_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic read_req, write_req, invalid_req;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] wb_line;
  logic ace_ready, resp_err, busy;
  logic [LINE_W-1:0] fill_line;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [3:0] arsnoop;
  logic [2:0] awsnoop;
  logic arvalid, arready, rvalid, rready, rlast, rack;
  logic [DATA_W-1:0] rdata, wdata;
  logic [3:0] rresp;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready, wack;
  logic [DATA_W/8-1:0] wstrb;
  logic [1:0] bresp;

  always #5 clk = ~clk;

  ace_request_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset), .read_req(read_req), .write_req(write_req),
    .invalid_req(invalid_req), .req_addr(req_addr), .wb_line(wb_line),
    .ace_ready(ace_ready), .resp_err(resp_err), .busy(busy), .fill_line(fill_line),
    .araddr(araddr), .arlen(arlen), .arsnoop(arsnoop), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .rack(rack), .awaddr(awaddr), .awlen(awlen), .awsnoop(awsnoop),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wack(wack)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave knobs
  int ar_stall, ar_wait, rb, rlast_at, err_beat;
  bit r_gap, r_phase, w_toggle, w_phase, ar_seen;
  logic [3:0] err_resp;
  logic [1:0] bresp_k;
  logic [31:0] rwords [4];
  // Slave logs
  int ar_cnt, aw_cnt, w_cnt, ar_unstable, ready_pulses, strb_bad;
  logic [31:0] ar_addr0, aw_addr0;
  logic [7:0] ar_len0, aw_len0;
  logic [3:0] ar_snoop0;
  logic [2:0] aw_snoop0;
  logic [31:0] wlog [8];
  logic wlast_log [8];

  task automatic clr();
    ar_stall = 0; ar_wait = 0; rb = 0; rlast_at = 3; err_beat = -1; err_resp = 4'b0;
    r_gap = 0; r_phase = 0; w_toggle = 0; w_phase = 0; ar_seen = 0; bresp_k = 2'b00;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; ar_unstable = 0; ready_pulses = 0; strb_bad = 0;
    ar_addr0 = '0; aw_addr0 = '0; ar_len0 = '0; aw_len0 = '0; ar_snoop0 = '0;
    aw_snoop0 = '0;
    for (int i = 0; i < 8; i++) begin
      wlog[i] = '0;
      wlast_log[i] = 1'b0;
    end
  endtask

  // Drives the slave side for the current cycle from the engine's registered outputs.
  task automatic slave_drive();
    arready = 1'b0;
    if (arvalid) begin
      if (!ar_seen) begin
        ar_seen = 1; ar_addr0 = araddr; ar_snoop0 = arsnoop; ar_len0 = arlen;
      end else if (araddr != ar_addr0 || arsnoop != ar_snoop0 || arlen != ar_len0) begin
        ar_unstable++;
      end
      arready = (ar_wait >= ar_stall);
      if (arready) begin
        ar_cnt++; ar_wait = 0; ar_seen = 0;
      end else begin
        ar_wait++;
      end
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 4'b0; rdata = '0;
    if (rready) begin
      if (!(r_gap && r_phase)) begin
        rvalid = 1'b1;
        rdata  = rwords[rb % 4];
        rresp  = (rb == err_beat) ? err_resp : 4'b0;
        rlast  = (rb == rlast_at);
        rb++;
      end
      r_phase = !r_phase;
    end
    awready = 1'b1;
    if (awvalid) begin
      aw_cnt++; aw_addr0 = awaddr; aw_snoop0 = awsnoop; aw_len0 = awlen;
    end
    wready = w_toggle ? w_phase : 1'b1;
    w_phase = !w_phase;
    if (wvalid && wstrb != '1) strb_bad++;
    if (wvalid && wready && w_cnt < 8) begin
      wlog[w_cnt] = wdata; wlast_log[w_cnt] = wlast; w_cnt++;
    end
    bvalid = bready;
    bresp  = bresp_k;
    if (ace_ready) ready_pulses++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    slave_drive();
  endtask

  // Issues one request and steps until ace_ready (bounded); lat = edges since request.
  task automatic run(input logic rd, input logic wr, input logic inv,
                     input logic [31:0] addr, input logic [127:0] line, output int lat);
    read_req = rd; write_req = wr; invalid_req = inv; req_addr = addr; wb_line = line;
    step();
    lat = 1;
    read_req = 1'b0; write_req = 1'b0; invalid_req = 1'b0;
    while (!ace_ready && lat < 60) begin
      step();
      lat++;
    end
  endtask

  int lat;
  int n;

  initial begin
    read_req = 0; write_req = 0; invalid_req = 0; req_addr = '0; wb_line = '0;
    arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    clr();
    rwords = '{32'h0, 32'h0, 32'h0, 32'h0};
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_ace_ready", ace_ready, 0);
    check("rst_fill", fill_line, 0);
    reset = 1'b1;
    step();

    // Plain fill
    clr();
    rwords = '{32'hA, 32'hB, 32'hC, 32'hD};
    run(1, 0, 0, 32'h1234, '0, lat);
    check("fill_lat", lat, 6);
    check("fill_araddr", ar_addr0, 32'h1230);
    check("fill_arlen", ar_len0, 3);
    check("fill_arsnoop", ar_snoop0, 4'b0001);
    check("fill_line", fill_line, 128'h0000000D_0000000C_0000000B_0000000A);
    check("fill_rack", rack, 1);
    check("fill_wack", wack, 0);
    check("fill_err", resp_err, 0);
    step();
    check("fill_ready_drop", ace_ready, 0);
    check("fill_idle", busy, 0);

    // Backpressure on AR and gaps on R
    clr();
    ar_stall = 3; r_gap = 1;
    rwords = '{32'h11, 32'h12, 32'h13, 32'h14};
    run(1, 0, 0, 32'h2008, '0, lat);
    check("bp_lat", lat, 12);
    check("bp_ar_stable", ar_unstable, 0);
    check("bp_araddr", ar_addr0, 32'h2000);
    check("bp_fill", fill_line, 128'h00000014_00000013_00000012_00000011);
    repeat (3) step();
    check("bp_pulses", ready_pulses, 1);

    // Writeback with toggling wready
    clr();
    w_toggle = 1;
    run(0, 1, 0, 32'h300C, 128'h00000004_00000003_00000002_00000001, lat);
    check("wb_lat", lat, 10);
    check("wb_awaddr", aw_addr0, 32'h3000);
    check("wb_awsnoop", aw_snoop0, 3'b011);
    check("wb_awlen", aw_len0, 3);
    check("wb_wcnt", w_cnt, 4);
    check("wb_wdata", {wlog[3], wlog[2], wlog[1], wlog[0]},
          128'h00000004_00000003_00000002_00000001);
    check("wb_wlast", {wlast_log[3], wlast_log[2], wlast_log[1], wlast_log[0]}, 4'b1000);
    check("wb_wstrb", strb_bad, 0);
    check("wb_wack", wack, 1);
    check("wb_rack", rack, 0);
    check("wb_err", resp_err, 0);
    check("wb_fill_kept", fill_line, 128'h00000014_00000013_00000012_00000011);
    step();

    // MakeUnique
    clr();
    rlast_at = 0;
    rwords = '{32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD};
    run(0, 0, 1, 32'h4444, '0, lat);
    check("inv_lat", lat, 3);
    check("inv_arsnoop", ar_snoop0, 4'b1100);
    check("inv_arlen", ar_len0, 0);
    check("inv_rack", rack, 1);
    check("inv_err", resp_err, 0);
    check("inv_fill_kept", fill_line, 128'h00000014_00000013_00000012_00000011);
    step();

    // rresp error on beat 2
    clr();
    err_beat = 2; err_resp = 4'b0010;
    rwords = '{32'h21, 32'h22, 32'h23, 32'h24};
    run(1, 0, 0, 32'h5000, '0, lat);
    check("rresp_lat", lat, 6);
    check("rresp_err", resp_err, 1);
    step();
    check("rresp_err_drop", resp_err, 0);

    // Early rlast on beat 1: still four beats consumed
    clr();
    rlast_at = 1;
    run(1, 0, 0, 32'h6000, '0, lat);
    check("rlast_lat", lat, 6);
    check("rlast_beats", rb, 4);
    check("rlast_err", resp_err, 1);
    step();

    // Clean read right after an error, requested in the IDLE cycle after DONE
    clr();
    rwords = '{32'h31, 32'h32, 32'h33, 32'h34};
    run(1, 0, 0, 32'h7000, '0, lat);
    check("clean_lat", lat, 6);
    check("clean_err", resp_err, 0);
    check("clean_fill", fill_line, 128'h00000034_00000033_00000032_00000031);
    step();

    // bresp error
    clr();
    bresp_k = 2'b10;
    run(0, 1, 0, 32'h8000, 128'h1, lat);
    check("bresp_err", resp_err, 1);
    step();

    // write + read together: writeback wins
    clr();
    run(1, 1, 0, 32'h9000, 128'h5, lat);
    check("prio_wack", wack, 1);
    check("prio_rack", rack, 0);
    check("prio_ar", ar_cnt, 0);
    check("prio_aw", aw_cnt, 1);
    step();

    // Requests while busy are ignored
    clr();
    read_req = 1; req_addr = 32'hA000;
    step();
    read_req = 0;
    step();
    write_req = 1; invalid_req = 1;
    step();
    write_req = 0; invalid_req = 0;
    n = 0;
    while (!ace_ready && n < 60) begin
      step();
      n++;
    end
    check("busy_done", ace_ready, 1);
    step();
    step();
    check("busy_idle", busy, 0);
    check("busy_no_aw", aw_cnt, 0);
    check("busy_one_ar", ar_cnt, 1);

    // Reset in the middle of W_SEND
    clr();
    w_toggle = 1;
    write_req = 1; req_addr = 32'hB000; wb_line = 128'h7;
    step();
    write_req = 0;
    n = 0;
    while (!wvalid && n < 10) begin
      step();
      n++;
    end
    check("mid_w_reached", wvalid, 1);
    reset = 1'b0;
    #1;
    check("mid_w_wvalid", wvalid, 0);
    check("mid_w_busy", busy, 0);
    step();
    reset = 1'b1;
    step();
    check("mid_w_idle", busy, 0);
    check("mid_w_awvalid", awvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
